vga_rect_writer: RTL

- Drawing engine that drives the pixel-write port (x, y, color, write) of vga_adapter, the port the VGA top level currently ties to zero.
- Accepts one rectangle request at a time over a valid/ready handshake.
- Emits one pixel write per cycle in raster order, with an optional 1-pixel border colour.
- Used by the Tetris renderer to paint playfield cells, blocks and erase regions over the MIF background.

---
 rtl/vga_rect_writer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_rect_writer.sv
// vga_rect_writer
//   Rectangle drawing engine feeding the pixel-write port of vga_adapter.
//   Accepts one rectangle per valid/ready handshake and emits one pixel
//   write per cycle in raster order, with an optional 1-pixel border colour.
//   Pixels falling outside the H_RES x V_RES screen are suppressed (write=0)
//   while the counters keep advancing, so timing depends only on w*h.
//
// Ports
//   clock, resetn        : single clock, synchronous active-low reset
//   req_valid/req_ready  : request handshake (accepted only in IDLE)
//   req_x, req_y         : top-left corner
//   req_w, req_h         : rectangle size; zero in either means no writes
//   req_fill/req_border  : interior / edge colours
//   req_border_en        : 1 = edge pixels use req_border
//   busy                 : engine in DRAW or DONE
//   done                 : one-cycle pulse on completion
//   x, y, color, write   : registered pixel-write port to vga_adapter
module vga_rect_writer #(
   parameter int NX          = 10,
   parameter int NY          = 9,
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int COLOR_DEPTH = 9,
   parameter int DIM_W       = 6
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [NX-1:0]          req_x,
   input  logic [NY-1:0]          req_y,
   input  logic [DIM_W-1:0]       req_w,
   input  logic [DIM_W-1:0]       req_h,
   input  logic [COLOR_DEPTH-1:0] req_fill,
   input  logic [COLOR_DEPTH-1:0] req_border,
   input  logic                   req_border_en,
   output logic                   busy,
   output logic                   done,
   output logic [NX-1:0]          x,
   output logic [NY-1:0]          y,
   output logic [COLOR_DEPTH-1:0] color,
   output logic                   write
);

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

   localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);
   localparam logic [NX:0]      H_LIM = (NX+1)'(H_RES);
   localparam logic [NY:0]      V_LIM = (NY+1)'(V_RES);

   state_t                   state, state_n;
   logic [NX-1:0]            x0_r, x0_n;
   logic [NY-1:0]            y0_r, y0_n;
   logic [DIM_W-1:0]         w_r, w_n, h_r, h_n;
   logic [COLOR_DEPTH-1:0]   fill_r, fill_n, border_r, border_n;
   logic                     ben_r, ben_n;
   logic [DIM_W-1:0]         cx, cx_n, cy, cy_n;
   logic [NX-1:0]            x_n;
   logic [NY-1:0]            y_n;
   logic [COLOR_DEPTH-1:0]   color_n;
   logic                     write_n, done_n;

   // counter step for the pixel after the one currently on the outputs
   logic                     last_col, last_row;
   logic [DIM_W-1:0]         nxt_cx, nxt_cy;

   // operands of the pixel generator: the incoming request at acceptance,
   // the latched request with the stepped counters while drawing
   logic [NX-1:0]            op_x0;
   logic [NY-1:0]            op_y0;
   logic [DIM_W-1:0]         op_w, op_h, op_cx, op_cy;
   logic [COLOR_DEPTH-1:0]   op_fill, op_border;
   logic                     op_ben;

   logic [NX:0]              sum_x;
   logic [NY:0]              sum_y;
   logic                     pix_ok, pix_edge;
   logic [COLOR_DEPTH-1:0]   pix_color;

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_comb begin
      last_col = (cx == w_r - ONE);
      last_row = (cy == h_r - ONE);
      nxt_cx   = last_col ? '0 : cx + ONE;
      nxt_cy   = last_col ? cy + ONE : cy;
   end

   always_comb begin
      if (state == IDLE) begin
         op_x0     = req_x;
         op_y0     = req_y;
         op_w      = req_w;
         op_h      = req_h;
         op_cx     = '0;
         op_cy     = '0;
         op_fill   = req_fill;
         op_border = req_border;
         op_ben    = req_border_en;
      end else begin
         op_x0     = x0_r;
         op_y0     = y0_r;
         op_w      = w_r;
         op_h      = h_r;
         op_cx     = nxt_cx;
         op_cy     = nxt_cy;
         op_fill   = fill_r;
         op_border = border_r;
         op_ben    = ben_r;
      end
   end

   always_comb begin
      sum_x     = {1'b0, op_x0} + (NX+1)'(op_cx);
      sum_y     = {1'b0, op_y0} + (NY+1)'(op_cy);
      pix_ok    = (sum_x < H_LIM) && (sum_y < V_LIM);
      pix_edge  = op_ben && ((op_cx == '0) || (op_cx == op_w - ONE) ||
                             (op_cy == '0) || (op_cy == op_h - ONE));
      pix_color = pix_edge ? op_border : op_fill;
   end

   always_comb begin
      state_n  = state;
      x0_n     = x0_r;
      y0_n     = y0_r;
      w_n      = w_r;
      h_n      = h_r;
      fill_n   = fill_r;
      border_n = border_r;
      ben_n    = ben_r;
      cx_n     = cx;
      cy_n     = cy;
      x_n      = x;
      y_n      = y;
      color_n  = color;
      write_n  = 1'b0;
      done_n   = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               x0_n     = req_x;
               y0_n     = req_y;
               w_n      = req_w;
               h_n      = req_h;
               fill_n   = req_fill;
               border_n = req_border;
               ben_n    = req_border_en;
               cx_n     = '0;
               cy_n     = '0;
               if (req_w == '0 || req_h == '0) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end else begin
                  // first pixel is registered on the acceptance edge
                  state_n = DRAW;
                  x_n     = sum_x[NX-1:0];
                  y_n     = sum_y[NY-1:0];
                  color_n = pix_color;
                  write_n = pix_ok;
               end
            end
         end
         DRAW: begin
            if (last_col && last_row) begin
               state_n = DONE;
               done_n  = 1'b1;
            end else begin
               cx_n    = nxt_cx;
               cy_n    = nxt_cy;
               x_n     = sum_x[NX-1:0];
               y_n     = sum_y[NY-1:0];
               color_n = pix_color;
               write_n = pix_ok;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state    <= IDLE;
         x0_r     <= '0;
         y0_r     <= '0;
         w_r      <= '0;
         h_r      <= '0;
         fill_r   <= '0;
         border_r <= '0;
         ben_r    <= 1'b0;
         cx       <= '0;
         cy       <= '0;
         x        <= '0;
         y        <= '0;
         color    <= '0;
         write    <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         x0_r     <= x0_n;
         y0_r     <= y0_n;
         w_r      <= w_n;
         h_r      <= h_n;
         fill_r   <= fill_n;
         border_r <= border_n;
         ben_r    <= ben_n;
         cx       <= cx_n;
         cy       <= cy_n;
         x        <= x_n;
         y        <= y_n;
         color    <= color_n;
         write    <= write_n;
         done     <= done_n;
      end
   end

endmodule
